// File: rtl/pong_pkg.sv
// Shared pong types and widths: coordinate/colour widths and the paddle FSM state encoding.
// Pure declarations; no latency and no backpressure.
package pong_pkg;
    localparam int COORD_W = 10;
    localparam int COLOR_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } paddle_state_t;

    // Conflicting or absent requests both resolve to IDLE.
    function automatic paddle_state_t req_to_state(input logic req_up, input logic req_dn);
        paddle_state_t s;
        s = IDLE;
        if (req_up && !req_dn) begin
            s = UP;
        end else if (req_dn && !req_up) begin
            s = DOWN;
        end
        return s;
    endfunction
endpackage

// File: rtl/paddle_ctrl_if.sv
// Paddle control bundle: joystick/tick/pixel-probe inputs and paddle geometry/pixel outputs.
// Wires only; no latency and no backpressure.
interface paddle_ctrl_if;
    import pong_pkg::*;

    logic               tick;
    logic               up;
    logic               down;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic               auto_mode;
    logic [COORD_W-1:0] ball_y;

    logic [COLOR_W-1:0] rgb;
    logic               pix_on;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic [7:0]         size_x;
    logic [7:0]         size_y;
    logic [2:0]         speed_div;
    logic               moving;

    modport master (
        output tick, up, down, row, col, auto_mode, ball_y,
        input  rgb, pix_on, pos_x, pos_y, size_x, size_y, speed_div, moving
    );

    modport slave (
        input  tick, up, down, row, col, auto_mode, ball_y,
        output rgb, pix_on, pos_x, pos_y, size_x, size_y, speed_div, moving
    );
endinterface

// File: rtl/paddle_speed_gen.sv
// Tick divider with step-count acceleration; move strobe is combinational on the qualifying tick.
// No backpressure: clr wins over tick_en and restores the resting divisor.
module paddle_speed_gen #(
    parameter int BASE_DIV    = 5,
    parameter int MIN_DIV     = 2,
    parameter int ACCEL_STEPS = 40
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       tick_en,
    output logic       move,
    output logic [2:0] speed_div
);
    localparam int SW = (ACCEL_STEPS > 1) ? $clog2(ACCEL_STEPS) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(ACCEL_STEPS - 1);

    logic [2:0]    div_cnt;
    logic [SW-1:0] step_cnt;

    assign move = tick_en && (div_cnt == (speed_div - 3'd1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            step_cnt  <= '0;
            speed_div <= 3'(BASE_DIV);
        end else if (clr) begin
            div_cnt   <= '0;
            step_cnt  <= '0;
            speed_div <= 3'(BASE_DIV);
        end else if (tick_en) begin
            if (move) begin
                div_cnt <= '0;
                if (step_cnt == STEP_LAST) begin
                    step_cnt <= '0;
                    if (speed_div > 3'(MIN_DIV)) begin
                        speed_div <= speed_div - 3'd1;
                    end
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 3'd1;
            end
        end
    end
endmodule

// File: rtl/paddle_ctrl.sv
// Joystick (or, with PADDLE_AUTO_EN, ball-tracking) paddle with accelerating motion and a pixel hit test.
// pix_on/rgb lag row/col by one cycle; no backpressure, requests are sampled every clock.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter logic [COLOR_W-1:0] COLOR = 3'b111,
    parameter int PAD_W       = 8,
    parameter int PAD_H       = 80,
    parameter int X_POS       = 5,
    parameter int START_Y     = 100,
    parameter int LIMIT_Y_MIN = 5,
    parameter int LIMIT_Y_MAX = 475,
    parameter int STEP        = 1,
    parameter int BASE_DIV    = 5,
    parameter int MIN_DIV     = 2,
    parameter int ACCEL_STEPS = 40,
    parameter int DEADBAND    = 4
) (
    input  logic          clock,
    input  logic          reset,
    paddle_ctrl_if.slave  pif
);
    localparam int CW1   = COORD_W + 1;
    localparam int Y_BOT = LIMIT_Y_MAX - PAD_H;

    generate
        if (!(LIMIT_Y_MIN <= START_Y && START_Y <= Y_BOT)) begin : g_bad_start_y
            $error("paddle_ctrl: START_Y outside [LIMIT_Y_MIN, LIMIT_Y_MAX-PAD_H]");
        end
        if (!(1 <= MIN_DIV && MIN_DIV <= BASE_DIV && BASE_DIV <= 7)) begin : g_bad_div
            $error("paddle_ctrl: need 1 <= MIN_DIV <= BASE_DIV <= 7");
        end
        if (ACCEL_STEPS < 1) begin : g_bad_accel
            $error("paddle_ctrl: ACCEL_STEPS must be at least 1");
        end
    endgenerate

    paddle_state_t      state;
    paddle_state_t      next_state;
    logic               clr;
    logic               tick_en;
    logic               move;
    logic               eff_up;
    logic               eff_dn;
    logic [COORD_W-1:0] pos_y;
    logic [CW1-1:0]     pos_w;
    logic [COORD_W-1:0] up_nxt;
    logic [COORD_W-1:0] dn_nxt;
    logic               hit;

    assign pos_w = {1'b0, pos_y};

`ifdef PADDLE_AUTO_EN
    logic [CW1-1:0] ctr_w;
    logic [CW1-1:0] ball_w;
    logic           auto_up;
    logic           auto_dn;

    // Track the paddle centre against the ball with a symmetric deadband.
    assign ctr_w   = pos_w + CW1'(PAD_H / 2);
    assign ball_w  = {1'b0, pif.ball_y};
    assign auto_up = (ball_w + CW1'(DEADBAND)) < ctr_w;
    assign auto_dn = ball_w > (ctr_w + CW1'(DEADBAND));
    assign eff_up  = pif.auto_mode ? auto_up : pif.up;
    assign eff_dn  = pif.auto_mode ? auto_dn : pif.down;
`else
    logic unused_auto;
    assign unused_auto = ^{pif.auto_mode, pif.ball_y};
    assign eff_up      = pif.up;
    assign eff_dn      = pif.down;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Counters stay cleared in IDLE and reset on any change of direction.
    always_comb begin
        next_state = IDLE;
        clr        = 1'b0;
        next_state = req_to_state(eff_up, eff_dn);
        clr        = (next_state != state) || (state == IDLE);
    end

    assign tick_en = pif.tick && !clr;

    paddle_speed_gen #(
        .BASE_DIV    (BASE_DIV),
        .MIN_DIV     (MIN_DIV),
        .ACCEL_STEPS (ACCEL_STEPS)
    ) u_speed (
        .clock     (clock),
        .reset     (reset),
        .clr       (clr),
        .tick_en   (tick_en),
        .move      (move),
        .speed_div (pif.speed_div)
    );

    // Limit compares run one bit wider so pos_y - STEP can never wrap.
    assign up_nxt = (pos_w >= CW1'(LIMIT_Y_MIN + STEP)) ? (pos_y - COORD_W'(STEP))
                                                         : COORD_W'(LIMIT_Y_MIN);
    assign dn_nxt = ((pos_w + CW1'(STEP)) >= CW1'(Y_BOT)) ? COORD_W'(Y_BOT)
                                                          : (pos_y + COORD_W'(STEP));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos_y <= COORD_W'(START_Y);
        end else if (move) begin
            pos_y <= (state == UP) ? up_nxt : dn_nxt;
        end
    end

    assign hit = ({1'b0, pif.col} >= CW1'(X_POS)) &&
                 ({1'b0, pif.col} <  CW1'(X_POS + PAD_W)) &&
                 ({1'b0, pif.row} >= pos_w) &&
                 ({1'b0, pif.row} <  (pos_w + CW1'(PAD_H)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pif.pix_on <= 1'b0;
            pif.rgb    <= '0;
        end else begin
            pif.pix_on <= hit;
            pif.rgb    <= hit ? COLOR : '0;
        end
    end

    assign pif.pos_y  = pos_y;
    assign pif.pos_x  = COORD_W'(X_POS);
    assign pif.size_x = 8'(PAD_W);
    assign pif.size_y = 8'(PAD_H);
    assign pif.moving = (state != IDLE);
endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 The block SHALL expose parameters as: name, default, meaning. COLOR, 3'b111, paddle colour. PAD_W, 8, width in px. PAD_H, 80, height in px. X_POS, 5, fixed left column. START_Y, 100, reset top row. LIMIT_Y_MIN, 5, top limit. LIMIT_Y_MAX, 475, bottom limit, exclusive. STEP, 1, px per move. BASE_DIV, 5, ticks per move at rest. MIN_DIV, 2, fastest ticks per move. ACCEL_STEPS, 40, moves per speed-up. DEADBAND, 4, auto-mode tolerance in px.
REQ-002 clock  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 tick  in  1  one-cycle movement strobe.
REQ-005 up / down  in  1 each  active-high joystick requests.
REQ-006 row / col  in  10 each  pixel being rendered.
REQ-007 auto_mode  in  1; ball_y  in  10  auto-tracking inputs, ignored unless PADDLE_AUTO_EN is defined.
REQ-008 rgb  out  3  pixel colour; pix_on  out  1  pixel hit.
REQ-009 pos_x, pos_y  out  10; size_x, size_y  out  8  paddle geometry.
REQ-010 speed_div  out  3  current ticks per move; moving  out  1  FSM not in IDLE.

Function
REQ-011 FSM states SHALL be IDLE, UP and DOWN, with the next state evaluated on every clock, not only on tick.
REQ-012 Transitions: up&!down -> UP; down&!up -> DOWN; neither or both -> IDLE.
REQ-013 Entering IDLE, or any direction change, SHALL set div_cnt=0, step_cnt=0 and speed_div=BASE_DIV in the same cycle.
REQ-014 In UP/DOWN, each tick SHALL increment div_cnt; at div_cnt==speed_div-1 a move SHALL occur and div_cnt SHALL clear.
REQ-015 A move SHALL increment step_cnt; at step_cnt==ACCEL_STEPS-1, step_cnt SHALL clear and speed_div SHALL decrement if greater than MIN_DIV.
REQ-016 An UP move SHALL set pos_y=max(LIMIT_Y_MIN, pos_y-STEP), computed without unsigned underflow.
REQ-017 A DOWN move SHALL set pos_y=min(LIMIT_Y_MAX-PAD_H, pos_y+STEP).
REQ-018 A move blocked by a limit SHALL still count toward acceleration.
REQ-019 pix_on SHALL be registered with 1-cycle latency: 1 iff X_POS<=col<X_POS+PAD_W and pos_y<=row<pos_y+PAD_H.
REQ-020 rgb SHALL be COLOR when pix_on=1 and 0 otherwise, aligned with pix_on.
REQ-021 pos_x=X_POS, size_x=PAD_W and size_y=PAD_H SHALL be constant.
REQ-022 Parameters SHALL satisfy LIMIT_Y_MIN<=START_Y<=LIMIT_Y_MAX-PAD_H, 1<=MIN_DIV<=BASE_DIV<=7 and ACCEL_STEPS>=1; a violation SHALL fail elaboration.

Reset
REQ-023 reset=1 SHALL immediately force state=IDLE, pos_y=START_Y, speed_div=BASE_DIV, div_cnt=0, step_cnt=0, pix_on=0, rgb=0 and moving=0, including mid-move.
REQ-024 After reset deasserts, the first movement SHALL require a full BASE_DIV ticks.

Configuration
REQ-025 With PADDLE_AUTO_EN defined and auto_mode=1, the FSM SHALL ignore up/down and derive its direction from c=pos_y+PAD_H/2.
REQ-026 In auto mode: UP if ball_y+DEADBAND<c, DOWN if ball_y>c+DEADBAND, else IDLE.
REQ-027 Without PADDLE_AUTO_EN, auto_mode and ball_y SHALL have no effect and no auto logic SHALL be synthesised.

Structure
REQ-028 Shared package pong_pkg SHALL hold COORD_W=10, COLOR_W=3 and the paddle_state_t enum (IDLE, UP, DOWN).
REQ-029 Divider and acceleration counters SHALL live in sub-module paddle_speed_gen, which outputs a move strobe and speed_div.

Verification
REQ-030 Reset asserted, no clock edge -> pos_y=100, speed_div=5, moving=0, rgb=0.
REQ-031 up=1, tick every cycle -> pos_y=99 after 5th tick; speed_div=4 after 40th move; speed_div floors at 2.
REQ-032 down=1 from pos_y=390 -> pos_y reaches 395 and stays there; up=1 at pos_y=5 -> pos_y stays 5.
REQ-033 up=down=1 after acceleration -> next cycle moving=0, speed_div=5, pos_y unchanged; reset pulse mid-move -> pos_y=100 at once.
REQ-034 pos_y=100: row=100,col=5 -> rgb=3'b111 one cycle later; col=13 or row=180 -> rgb=0.
REQ-035 PADDLE_AUTO_EN, auto_mode=1, ball_y=300, pos_y=100 -> state DOWN; ball_y=141 -> IDLE.
